// File: rtl/my_pc_pkg.sv
// Shared definitions for the my_pc_16 program counter: datapath width,
// default return-stack depth, the command enum and its priority decoder.
package my_pc_pkg;

  localparam int PC_W                = 16;
  localparam int DEFAULT_STACK_DEPTH = 4;

  // One command acts per cycle; this is what the priority decoder selects.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_RET,
    OP_CALL
  } pc_op_t;

  // Priority: call > ret > load > inc > hold (reset is handled by the register).
  function automatic pc_op_t decode_op(input logic call,
                                       input logic ret,
                                       input logic load,
                                       input logic inc);
    pc_op_t op;
    if (call)      op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (load) op = OP_LOAD;
    else if (inc)  op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/my_incrementer_16.sv
// 16-bit incrementer: sum = a + 1 modulo 2^16. The single adder on the PC
// path; its result is shared by the inc and call commands.
module my_incrementer_16
  import my_pc_pkg::*;
(
  input  logic [PC_W-1:0] a,
  output logic [PC_W-1:0] sum
);

  // Wraps naturally from 16'hFFFF to 16'h0000.
  assign sum = a + PC_W'(1);

endmodule

// File: rtl/my_pc_16.sv
// Program counter with jump, increment, call and return, backed by a small
// return-address stack. Synchronous active-high reset.
// Optional feature: define MY_PC_WRAP_FLAG_EN to add the sticky 'wrap'
// output, which records any increment of 16'hFFFF to 16'h0000.
module my_pc_16
  import my_pc_pkg::*;
#(
  // Return-stack entries; legal values are powers of two from 2 to 16.
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] in,
  input  logic            load,
  input  logic            inc,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] out,
  output logic            full,
  output logic            empty,
`ifdef MY_PC_WRAP_FLAG_EN
  output logic            wrap,
`endif
  output logic            err
);

  localparam int ADDR_W = $clog2(STACK_DEPTH);
  localparam int SP_W   = ADDR_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus1;
  logic            pc_carry;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W-1:0] sp_m1;
  logic            err_q, err_d;
  logic            push_en;
  pc_op_t          op;
  logic [PC_W-1:0] stack_mem [STACK_DEPTH];

  // Shared out+1 for both inc and the call return address.
  my_incrementer_16 u_inc (
    .a   (pc_q),
    .sum (pc_plus1)
  );

  // The incrementer's final carry: only out == 16'hFFFF rolls over.
  assign pc_carry = (pc_q == {PC_W{1'b1}});

  assign sp_m1 = sp_q - SP_ONE;
  assign full  = (sp_q == SP_FULL);
  assign empty = (sp_q == '0);
  assign out   = pc_q;
  assign err   = err_q;

  // Next-state decode for pc, stack pointer and the misuse flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    op      = decode_op(call, ret, load, inc);
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    case (op)
      OP_CALL: begin
        pc_d = in;
        if (!full) begin
          push_en = 1'b1;
          sp_d    = sp_q + SP_ONE;
        end else begin
          err_d = 1'b1;
        end
      end
      OP_RET: begin
        if (!empty) begin
          pc_d = stack_mem[sp_m1[ADDR_W-1:0]];
          sp_d = sp_m1;
        end else begin
          err_d = 1'b1;
        end
      end
      OP_LOAD: pc_d = in;
      OP_INC:  pc_d = pc_plus1;
      default: ;
    endcase
  end

  // Control registers; reset wins over any command in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Return-address storage; written only by a successful call.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; sp returning to 0 makes old entries unreachable.
    if (push_en && !reset) begin
      stack_mem[sp_q[ADDR_W-1:0]] <= pc_plus1;
    end
  end

`ifdef MY_PC_WRAP_FLAG_EN
  logic wrap_q;

  // Sticky wrap: set by an inc rollover or a call that pushes 16'h0000.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else if (pc_carry && ((op == OP_INC) || push_en)) begin
      wrap_q <= 1'b1;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_my_pc_16.sv
// Self-checking bench for my_pc_16: directed scenarios followed by random
// command streams, compared against a queue-based reference model.
module tb_my_pc_16;
  import my_pc_pkg::*;

  localparam int DEPTH = DEFAULT_STACK_DEPTH;

  logic        clk = 1'b0;
  logic        reset, load, inc, call, ret;
  logic [15:0] in;
  logic [15:0] out;
  logic        full, empty, err;
`ifdef MY_PC_WRAP_FLAG_EN
  logic        wrap;
`endif

  my_pc_16 #(.STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .inc   (inc),
    .call  (call),
    .ret   (ret),
    .out   (out),
    .full  (full),
    .empty (empty),
`ifdef MY_PC_WRAP_FLAG_EN
    .wrap  (wrap),
`endif
    .err   (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: PC as an integer, return stack as a queue.
  int unsigned m_pc = 0;
  int unsigned m_stack[$];
  bit          m_err  = 1'b0;
  bit          m_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit rt, input bit l,
                            input bit i, input logic [15:0] a);
    if (r) begin
      m_pc = 0; m_stack.delete(); m_err = 0; m_wrap = 0;
    end else if (c) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back((m_pc + 1) % 65536);
        if (m_pc == 65535) m_wrap = 1;
      end else begin
        m_err = 1;
      end
      m_pc = a;
    end else if (rt) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else m_err = 1;
    end else if (l) begin
      m_pc = a;
    end else if (i) begin
      if (m_pc == 65535) m_wrap = 1;
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  // Drive one cycle of commands, advance the clock, then compare all outputs.
  task automatic cycle(input string tag, input bit r, input bit c, input bit rt,
                       input bit l, input bit i, input logic [15:0] a);
    reset = r; call = c; ret = rt; load = l; inc = i; in = a;
    @(posedge clk);
    #1;
    model_step(r, c, rt, l, i, a);
    check({tag, ".out"},   {16'h0, out},    m_pc);
    check({tag, ".empty"}, {31'h0, empty},  {31'h0, m_stack.size() == 0});
    check({tag, ".full"},  {31'h0, full},   {31'h0, m_stack.size() == DEPTH});
    check({tag, ".err"},   {31'h0, err},    {31'h0, m_err});
`ifdef MY_PC_WRAP_FLAG_EN
    check({tag, ".wrap"},  {31'h0, wrap},   {31'h0, m_wrap});
`endif
  endtask

  initial begin
    logic [15:0] lifo_exp [4];
    lifo_exp[0] = 16'h3001; lifo_exp[1] = 16'h2001;
    lifo_exp[2] = 16'h1001; lifo_exp[3] = 16'h0001;
    reset = 1'b1; call = 0; ret = 0; load = 0; inc = 0; in = '0;

    // Reset then three increments.
    cycle("rst", 1, 0, 0, 0, 0, 16'h0);
    check("rst.out_const", {16'h0, out}, 32'h0);
    check("rst.empty_const", {31'h0, empty}, 32'h1);
    check("rst.full_const", {31'h0, full}, 32'h0);
    for (int k = 0; k < 3; k++) cycle("inc3", 0, 0, 0, 0, 1, 16'h0);
    check("inc3.out_const", {16'h0, out}, 32'h3);

    // Load then increment; rollover at 16'hFFFF.
    cycle("load", 0, 0, 0, 1, 0, 16'h1234);
    check("load.out_const", {16'h0, out}, 32'h1234);
    cycle("load_inc", 0, 0, 0, 0, 1, 16'h0);
    check("load_inc.out_const", {16'h0, out}, 32'h1235);
    cycle("ld_ffff", 0, 0, 0, 1, 0, 16'hFFFF);
    cycle("wrap_inc", 0, 0, 0, 0, 1, 16'h0);
    check("wrap_inc.out_const", {16'h0, out}, 32'h0);
`ifdef MY_PC_WRAP_FLAG_EN
    check("wrap_inc.wrap_const", {31'h0, wrap}, 32'h1);
`endif

    // Nested call/return from 16'h0010.
    cycle("rst2", 1, 0, 0, 0, 0, 16'h0);
    cycle("ld10", 0, 0, 0, 1, 0, 16'h0010);
    cycle("call1", 0, 1, 0, 0, 0, 16'h0100);
    check("call1.out_const", {16'h0, out}, 32'h0100);
    cycle("call2", 0, 1, 0, 0, 0, 16'h0200);
    check("call2.out_const", {16'h0, out}, 32'h0200);
    cycle("ret1", 0, 0, 1, 0, 0, 16'h0);
    check("ret1.out_const", {16'h0, out}, 32'h0101);
    cycle("ret2", 0, 0, 1, 0, 0, 16'h0);
    check("ret2.out_const", {16'h0, out}, 32'h0011);
    check("ret2.empty_const", {31'h0, empty}, 32'h1);

    // Fill the stack, overflow, drain in LIFO order, underflow.
    cycle("rst3", 1, 0, 0, 0, 0, 16'h0);
    for (int k = 0; k < 4; k++) cycle("fill", 0, 1, 0, 0, 0, 16'(16'h1000 * (k + 1)));
    check("fill.full_const", {31'h0, full}, 32'h1);
    cycle("ovf", 0, 1, 0, 0, 0, 16'h5555);
    check("ovf.out_const", {16'h0, out}, 32'h5555);
    check("ovf.err_const", {31'h0, err}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      cycle("drain", 0, 0, 1, 0, 0, 16'h0);
      check("drain.out_const", {16'h0, out}, {16'h0, lifo_exp[k]});
    end
    cycle("udf", 0, 0, 1, 0, 0, 16'h0);
    check("udf.out_const", {16'h0, out}, 32'h0001);
    check("udf.empty_const", {31'h0, empty}, 32'h1);

    // All commands together: call wins.
    cycle("rst4", 1, 0, 0, 0, 0, 16'h0);
    cycle("prio", 0, 1, 1, 1, 1, 16'h0ABC);
    check("prio.out_const", {16'h0, out}, 32'h0ABC);
    check("prio.empty_const", {31'h0, empty}, 32'h0);
    cycle("prio_ret", 0, 0, 1, 0, 0, 16'h0);
    check("prio_ret.out_const", {16'h0, out}, 32'h0001);

    // Call from 16'hFFFF pushes 16'h0000.
    cycle("ld_ff2", 0, 0, 0, 1, 0, 16'hFFFF);
    cycle("call_ff", 0, 1, 0, 0, 0, 16'h0050);
    cycle("ret_ff", 0, 0, 1, 0, 0, 16'h0);
    check("ret_ff.out_const", {16'h0, out}, 32'h0);

    // Reset mid-sequence with sp=2, err=1, call asserted.
    cycle("rst5", 1, 0, 0, 0, 0, 16'h0);
    cycle("m_ld", 0, 0, 0, 1, 0, 16'hFFFF);
    cycle("m_inc", 0, 0, 0, 0, 1, 16'h0);
    cycle("m_ret", 0, 0, 1, 0, 0, 16'h0);
    cycle("m_c1", 0, 1, 0, 0, 0, 16'h0400);
    cycle("m_c2", 0, 1, 0, 0, 0, 16'h0500);
    check("m_c2.err_const", {31'h0, err}, 32'h1);
    cycle("m_rst", 1, 1, 0, 0, 0, 16'h0777);
    check("m_rst.out_const", {16'h0, out}, 32'h0);
    check("m_rst.err_const", {31'h0, err}, 32'h0);
    check("m_rst.empty_const", {31'h0, empty}, 32'h1);
`ifdef MY_PC_WRAP_FLAG_EN
    check("m_rst.wrap_const", {31'h0, wrap}, 32'h0);
`endif

    // Random command streams against the model.
    for (int n = 0; n < 800; n++) begin
      bit          r, c, rt, l, i;
      logic [15:0] a;
      r  = ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 99) < 25);
      rt = ($urandom_range(0, 99) < 25);
      l  = ($urandom_range(0, 99) < 20);
      i  = ($urandom_range(0, 99) < 60);
      a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      cycle("rand", r, c, rt, l, i, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
